// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef logic [31:0] instruction_type;

    localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_type;

    // Fetch addresses are word aligned; the low two bits are forced to zero.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Next-fetch-address register: synchronous reset, redirect and sequential advance.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc_reg
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= pc_align(RESET_PC);
        end else if (redirect) begin
            pc_reg <= pc_align(redirect_pc);
        end else if (advance) begin
            pc_reg <= pc_reg + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, single outstanding memory read
// and a one-entry hold buffer for responses that arrive while decode stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            FetchWrite,
    input  logic            PCSrc,
    input  logic [31:0]     pc_branch,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output instruction_type instruction,
    output logic [31:0]     pc,
    output logic            fetch_valid
);

    fetch_state_type state;
    logic [31:0]     pc_reg;
    logic [31:0]     pc_plus4;
    instruction_type buf_data;
    logic [31:0]     buf_pc;
    logic            resp_take;
    logic            have_instr;
    instruction_type avail_instr;
    logic [31:0]     avail_pc;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .rst        (rst),
        .redirect   (PCSrc),
        .redirect_pc(pc_branch),
        .advance    (resp_take),
        .pc_reg     (pc_reg)
    );

    assign pc_plus4 = pc_reg + 32'd4;
    assign imem_req = (state == REQ) || (state == DROP);

    // A response is consumed (to IF/ID or the hold buffer) unless a redirect kills it.
    assign resp_take   = (state == REQ) && imem_valid && !PCSrc;
    assign have_instr  = resp_take || (state == HOLD);
    assign avail_instr = (state == HOLD) ? buf_data : imem_rdata;
    assign avail_pc    = (state == HOLD) ? buf_pc : imem_addr;

    // NOTE: the hold buffer is pure datapath; its validity lives in the state,
    // so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (resp_take && !FetchWrite) begin
            buf_data <= imem_rdata;
            buf_pc   <= imem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_addr   <= 32'h0000_0000;
            instruction <= NOP_INSTRUCTION;
            pc          <= 32'h0000_0000;
            fetch_valid <= 1'b0;
        end else begin
            // A redirect squashes IF/ID but leaves pc as it was.
            if (PCSrc) begin
                instruction <= NOP_INSTRUCTION;
                fetch_valid <= 1'b0;
            end else if (FetchWrite) begin
                if (have_instr) begin
                    instruction <= avail_instr;
                    pc          <= avail_pc;
                    fetch_valid <= 1'b1;
                end else begin
                    instruction <= NOP_INSTRUCTION;
                    fetch_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (!PCSrc && PCWrite) begin
                        state     <= REQ;
                        imem_addr <= pc_reg;
                    end
                end
                REQ: begin
                    if (PCSrc) begin
                        state <= imem_valid ? IDLE : DROP;
                    end else if (imem_valid) begin
                        if (!FetchWrite) begin
                            state <= HOLD;
                        end else if (PCWrite) begin
                            imem_addr <= pc_plus4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (PCSrc) begin
                        state <= IDLE;
                    end else if (FetchWrite) begin
                        if (PCWrite) begin
                            state     <= REQ;
                            imem_addr <= pc_reg;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized
// traffic against an in-order instruction-stream scoreboard.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            PCWrite, FetchWrite, PCSrc;
    logic [31:0]     pc_branch;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    instruction_type instruction;
    logic [31:0]     pc;
    logic            fetch_valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .FetchWrite (FetchWrite),
        .PCSrc      (PCSrc),
        .pc_branch  (pc_branch),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .pc         (pc),
        .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pcw, fw, ps;
        logic [31:0] br;
        logic        iv;
        logic [31:0] rd;
        logic        chk, e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_instr, e_pc;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs[NVEC];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic r, pcw, fw, ps, input logic [31:0] br,
                                input logic iv, input logic [31:0] rd, input logic chk,
                                input logic er, input logic [31:0] ea, input logic efv,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.pcw = pcw; v.fw = fw; v.ps = ps; v.br = br; v.iv = iv; v.rd = rd;
        v.chk = chk; v.e_req = er; v.e_addr = ea; v.e_fv = efv;
        v.e_instr = efv ? ei : NOP_INSTRUCTION;
        v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random-phase scoreboard and memory model state
    logic [31:0] exp_pc;
    int          deliveries;
    logic        p_fw, p_ps, p_fv;
    logic [31:0] p_instr, p_pc;
    logic        pending;
    logic [31:0] maddr;
    int          elapsed, lat;

    initial begin
        // Directed sequence; expected outputs are those seen before the edge
        // that consumes the row's inputs.
        vecs[0]  = mk(1,1,1,0,0,0,0,                  0,0,0,0,0,0);
        vecs[1]  = mk(0,1,1,0,0,0,0,                  1,0,32'h0,0,0,0);
        vecs[2]  = mk(0,1,1,0,0,0,0,                  1,1,32'h0,0,0,0);
        vecs[3]  = mk(0,1,1,0,0,1,32'hA5A5_0000,      1,1,32'h0,0,0,0);
        vecs[4]  = mk(0,1,1,0,0,0,0,                  1,1,32'h4,1,32'hA5A5_0000,32'h0);
        vecs[5]  = mk(0,1,1,0,0,1,32'hA5A5_0004,      1,1,32'h4,0,0,0);
        vecs[6]  = mk(0,1,1,0,0,0,0,                  1,1,32'h8,1,32'hA5A5_0004,32'h4);
        vecs[7]  = mk(0,1,0,0,0,1,32'hA5A5_0008,      1,1,32'h8,0,0,0);
        vecs[8]  = mk(0,1,0,0,0,0,0,                  1,0,32'h8,0,0,0);
        vecs[9]  = mk(0,1,1,0,0,0,0,                  1,0,32'h8,0,0,0);
        vecs[10] = mk(0,1,1,1,32'h100,0,0,            1,1,32'hC,1,32'hA5A5_0008,32'h8);
        vecs[11] = mk(0,1,1,0,0,0,0,                  1,1,32'hC,0,0,0);
        vecs[12] = mk(0,1,1,0,0,0,0,                  1,1,32'hC,0,0,0);
        vecs[13] = mk(0,1,1,0,0,1,32'hA5A5_000C,      1,1,32'hC,0,0,0);
        vecs[14] = mk(0,1,1,0,0,0,0,                  1,0,32'hC,0,0,0);
        vecs[15] = mk(0,1,1,0,0,0,0,                  1,1,32'h100,0,0,0);
        vecs[16] = mk(0,1,1,1,32'h203,1,32'hA5A5_0100,1,1,32'h100,0,0,0);
        vecs[17] = mk(0,1,1,0,0,0,0,                  1,0,32'h100,0,0,0);
        vecs[18] = mk(0,1,1,0,0,0,0,                  1,1,32'h200,0,0,0);
        vecs[19] = mk(0,1,1,0,0,1,32'hA5A5_0200,      1,1,32'h200,0,0,0);
        vecs[20] = mk(0,1,1,1,32'hFFFF_FFFC,0,0,      1,1,32'h204,1,32'hA5A5_0200,32'h200);
        vecs[21] = mk(0,1,1,0,0,1,32'hA5A5_0204,      1,1,32'h204,0,0,0);
        vecs[22] = mk(0,1,1,0,0,0,0,                  1,0,32'h204,0,0,0);
        vecs[23] = mk(0,1,1,0,0,0,0,                  1,1,32'hFFFF_FFFC,0,0,0);
        vecs[24] = mk(0,1,1,0,0,1,32'h5A5A_FFFC,      1,1,32'hFFFF_FFFC,0,0,0);
        vecs[25] = mk(0,1,1,0,0,0,0,                  1,1,32'h0,1,32'h5A5A_FFFC,32'hFFFF_FFFC);
        vecs[26] = mk(0,1,1,0,0,1,32'hA5A5_0000,      1,1,32'h0,0,0,0);
        vecs[27] = mk(1,1,1,0,0,0,0,                  1,1,32'h4,1,32'hA5A5_0000,32'h0);
        vecs[28] = mk(0,1,1,0,0,0,0,                  1,0,32'h0,0,0,0);
        vecs[29] = mk(0,0,1,0,0,0,0,                  1,1,32'h0,0,0,0);

        rst = 1'b1; PCWrite = 1'b0; FetchWrite = 1'b1; PCSrc = 1'b0;
        pc_branch = '0; imem_valid = 1'b0; imem_rdata = '0;
        step();

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst; PCWrite = vecs[i].pcw; FetchWrite = vecs[i].fw;
            PCSrc = vecs[i].ps; pc_branch = vecs[i].br;
            imem_valid = vecs[i].iv; imem_rdata = vecs[i].rd;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
                check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
                check($sformatf("vec%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
                check($sformatf("vec%0d instruction", i), instruction, vecs[i].e_instr);
                if (vecs[i].e_fv)
                    check($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
            end
            step();
        end

        // Randomized traffic: every delivered instruction must be the next one
        // in program order from the last redirect target.
        rst = 1'b1; PCSrc = 1'b0; imem_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_pc = 32'h0; deliveries = 0; pending = 1'b0; elapsed = 0; lat = 1;
        p_fw = 1'b1; p_ps = 1'b0; p_fv = 1'b0; p_instr = NOP_INSTRUCTION; p_pc = 32'h0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (p_ps) begin
                check("rand squash fetch_valid", {31'd0, fetch_valid}, 32'd0);
                check("rand squash instruction", instruction, NOP_INSTRUCTION);
            end else if (!p_fw) begin
                check("rand stall fetch_valid", {31'd0, fetch_valid}, {31'd0, p_fv});
                check("rand stall instruction", instruction, p_instr);
                check("rand stall pc", pc, p_pc);
            end else if (fetch_valid) begin
                check("rand deliver pc", pc, exp_pc);
                check("rand deliver instruction", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end else begin
                check("rand bubble instruction", instruction, NOP_INSTRUCTION);
            end

            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (pending) begin
                check("rand request held", {imem_req, imem_addr}, {1'b1, maddr});
                elapsed++;
                if (elapsed >= lat) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(maddr);
                    pending = 1'b0;
                end
            end else if (imem_req) begin
                check("rand addr aligned", {30'd0, imem_addr[1:0]}, 32'd0);
                pending = 1'b1;
                maddr = imem_addr;
                elapsed = 0;
                lat = $urandom_range(1, 4);
            end

            PCWrite    = ($urandom_range(0, 3) != 0);
            FetchWrite = ($urandom_range(0, 3) != 0);
            PCSrc      = ($urandom_range(0, 15) == 0);
            pc_branch  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_0FFF);
            if (PCSrc)
                exp_pc = pc_branch & ~32'h3;

            p_fw = FetchWrite; p_ps = PCSrc; p_fv = fetch_valid;
            p_instr = instruction; p_pc = pc;
            step();
        end

        check("rand progress (deliveries >= 200)", {31'd0, deliveries >= 200}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
